// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath constants: register file geometry and named registers.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_defs;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_bypass.sv
// One read port's output mux: stored value, optional write-data bypass, $0 forced to zero.
// Latency: combinational, 0 cycles.
// Backpressure: none; the port is always valid.
module reg_file_bypass #(
  parameter int DATA_W = mips_defs::DATA_W,
  parameter int ADDR_W = mips_defs::REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] stored_data,
  input  logic              w_vld,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data
);

  logic hit;

  // Select bypassed write data on an address match; address 0 overrides everything.
  // w_vld is tested first so an undriven w_addr cannot leak into the result.
  always_comb begin
    hit    = (BYPASS != 0) && w_vld && (w_addr != '0) && (r_addr == w_addr);
    r_data = stored_data;
    if (hit) begin
      r_data = w_data;
    end
    if (r_addr == '0) begin
      r_data = '0;
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// 32x32 MIPS register file: two combinational read ports, one WB write port, debug port.
// Latency: reads 0 cycles; writes visible the cycle after the edge (same cycle if bypassed).
// Backpressure: none; every enabled write to a non-zero register commits.
module reg_file_wb #(
  parameter int DATA_W = mips_defs::DATA_W,
  parameter int ADDR_W = mips_defs::REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] r2_data,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [0:DEPTH-1];
  logic              w_vld;

  // A write only counts (and only bypasses) outside reset; during reset the
  // array is already zero, so all ports read 0.
  assign w_vld = w_en & ~rst;

  // Commit WB results and count them; $0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      wr_cnt <= '0;
    end else if (w_en && (w_addr != '0)) begin
      regs[w_addr] <= w_data;
      wr_cnt       <= wr_cnt + 16'd1;
    end
  end

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_r1 (
    .r_addr      (r1_addr),
    .stored_data (regs[r1_addr]),
    .w_vld       (w_vld),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .r_data      (r1_data)
  );

  reg_file_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_r2 (
    .r_addr      (r2_addr),
    .stored_data (regs[r2_addr]),
    .w_vld       (w_vld),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .r_data      (r2_data)
  );

  // Debug port shows committed state only, never the in-flight write.
  always_comb begin
    dbg_data = regs[dbg_addr];
    if (dbg_addr == '0) begin
      dbg_data = '0;
    end
  end

endmodule
